// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: S-box size, per-index loop length and the
// key-schedule FSM state encoding used by the KSA and decrypt stages.
package rc4_pkg;

  localparam int S_SIZE      = 256;
  localparam int LOOP_CYCLES = 8;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE       = 4'd0;
  localparam state_t ST_INIT       = 4'd1;
  localparam state_t ST_RD_SI_ADDR = 4'd2;
  localparam state_t ST_RD_SI_CAP  = 4'd3;
  localparam state_t ST_CALC_J     = 4'd4;
  localparam state_t ST_RD_SJ_ADDR = 4'd5;
  localparam state_t ST_RD_SJ_CAP  = 4'd6;
  localparam state_t ST_WR_SI      = 4'd7;
  localparam state_t ST_WR_SJ      = 4'd8;
  localparam state_t ST_NEXT_I     = 4'd9;
  localparam state_t ST_DONE       = 4'd10;

  // Cycles from the first INIT cycle to the DONE cycle.
  function automatic int ksa_run_cycles();
    return S_SIZE * (1 + LOOP_CYCLES);
  endfunction

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Selects one byte of the secret key by index; byte 0 is the most
// significant byte of the key bus.
module rc4_key_byte_sel #(
  parameter int KEY_LENGTH = 3,
  parameter int IDX_W      = 2
) (
  input  logic [8*KEY_LENGTH-1:0] key_i,
  input  logic [IDX_W-1:0]        idx_i,
  output logic [7:0]              byte_o
);

  always_comb begin
    byte_o = '0;
    for (int k = 0; k < KEY_LENGTH; k++) begin
      if (idx_i == IDX_W'(k)) byte_o = key_i[8*(KEY_LENGTH-1-k) +: 8];
    end
  end

endmodule

// File: rtl/rc4_ksa_fsm.sv
// RC4 key-scheduling FSM: initialises the S RAM to the identity permutation,
// then permutes it with the secret key using a single-port registered-read RAM.
module rc4_ksa_fsm
  import rc4_pkg::*;
#(
  parameter int KEY_LENGTH = 3
) (
  input  logic                    clock,
  input  logic                    i_reset,
  input  logic                    start,
  input  logic [8*KEY_LENGTH-1:0] secret_key,
  input  logic [7:0]              s_q,
  output logic [7:0]              address,
  output logic [7:0]              data,
  output logic                    s_wren,
  output logic                    busy,
  output logic                    finish
);

  localparam int         KIDX_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
  localparam logic [7:0] LAST_I = 8'(S_SIZE - 1);
  localparam logic [KIDX_W-1:0] LAST_KIDX = KIDX_W'(KEY_LENGTH - 1);

  state_t            state_q, state_d;
  logic [7:0]        i_q, i_d;
  logic [7:0]        j_q, j_d;
  logic [7:0]        si_q, si_d;
  logic [7:0]        sj_q, sj_d;
  logic [KIDX_W-1:0] kidx_q, kidx_d;
  logic [7:0]        key_byte;

  rc4_key_byte_sel #(
    .KEY_LENGTH (KEY_LENGTH),
    .IDX_W      (KIDX_W)
  ) u_key_sel (
    .key_i  (secret_key),
    .idx_i  (kidx_q),
    .byte_o (key_byte)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    kidx_d  = kidx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        i_d = i_q + 8'd1;
        if (i_q == LAST_I) state_d = ST_RD_SI_ADDR;
      end
      ST_RD_SI_ADDR: state_d = ST_RD_SI_CAP;
      ST_RD_SI_CAP: begin
        si_d    = s_q;
        state_d = ST_CALC_J;
      end
      ST_CALC_J: begin
        j_d     = j_q + si_q + key_byte;
        state_d = ST_RD_SJ_ADDR;
      end
      ST_RD_SJ_ADDR: state_d = ST_RD_SJ_CAP;
      ST_RD_SJ_CAP: begin
        sj_d    = s_q;
        state_d = ST_WR_SI;
      end
      ST_WR_SI: state_d = ST_WR_SJ;
      ST_WR_SJ: state_d = ST_NEXT_I;
      ST_NEXT_I: begin
        i_d    = i_q + 8'd1;
        kidx_d = (kidx_q == LAST_KIDX) ? '0 : kidx_q + 1'b1;
        state_d = (i_q == LAST_I) ? ST_DONE : ST_RD_SI_ADDR;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Both writes of a swap use values captured before either write, so an
  // i == j swap rewrites the same original byte twice.
  always_comb begin
    address = '0;
    data    = '0;
    s_wren  = 1'b0;
    case (state_q)
      ST_INIT: begin
        address = i_q;
        data    = i_q;
        s_wren  = 1'b1;
      end
      ST_RD_SI_ADDR, ST_RD_SI_CAP: address = i_q;
      ST_RD_SJ_ADDR, ST_RD_SJ_CAP: address = j_q;
      ST_WR_SI: begin
        address = i_q;
        data    = sj_q;
        s_wren  = 1'b1;
      end
      ST_WR_SJ: begin
        address = j_q;
        data    = si_q;
        s_wren  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign finish = (state_q == ST_DONE);

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      kidx_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      kidx_q  <= kidx_d;
    end
  end

endmodule
